// File: rtl/ssdd_scan.sv
// ssdd_scan: four-digit multiplexed seven-segment driver for the 4-bit up counter.
// Samples the counter once per frame, renders hex/decimal plus mode letter, flags wraps on dp.
module ssdd_scan #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DP_FRAMES   = 64
) (
    input  logic       ssdd_clk,
    input  logic       ssdd_rst,
    input  logic [3:0] ssdd_d,
    input  logic       ssdd_hex,
    output logic [3:0] ssdd_an,
    output logic [6:0] ssdd_seg,
    output logic       ssdd_dp
);
    localparam int unsigned     PreW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(REFRESH_DIV - 1);
    localparam logic [7:0]      DpLoad = 8'(DP_FRAMES);
    localparam logic [6:0]      SegOff = 7'h7F;
    localparam logic [6:0]      SegOne = 7'h79;
    localparam logic [6:0]      SegH   = 7'h09;
    localparam logic [6:0]      SegDec = 7'h21;

    logic [PreW-1:0] pre_q, pre_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      shadow_q, shadow_d;
    logic [3:0]      prev_q, prev_d;
    logic            mode_q, mode_d;
    logic            frame_q, frame_d;
    logic [7:0]      dp_cnt_q, dp_cnt_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic            tick;
    logic            frame_end;
    logic [3:0]      dec_units;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    always_comb begin
        tick      = (pre_q == PreMax);
        frame_end = tick && (idx_q == 2'd3);
        pre_d     = tick ? '0 : pre_q + 1'b1;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;

        shadow_d = shadow_q;
        mode_d   = mode_q;
        prev_d   = prev_q;
        if (frame_end) begin
            shadow_d = ssdd_d;
            mode_d   = ssdd_hex;
            prev_d   = shadow_q;
        end
        frame_d = frame_end;

        // Wrap is judged in the guard cycle after the latch, from the stored old/new pair.
        dp_cnt_d = dp_cnt_q;
        if (frame_q) begin
            if (shadow_q < prev_q) begin
                dp_cnt_d = DpLoad;
            end else if (dp_cnt_q != 8'd0) begin
                dp_cnt_d = dp_cnt_q - 8'd1;
            end
        end

        dec_units = (shadow_q >= 4'd10) ? shadow_q - 4'd10 : shadow_q;

        an_d  = 4'b1111;
        seg_d = SegOff;
        dp_d  = 1'b1;
        // A tick blanks the next cycle; the new digit appears one cycle later.
        if (!tick) begin
            an_d = ~(4'b0001 << idx_q);
            unique case (idx_q)
                2'd0: begin
                    seg_d = mode_q ? glyph(shadow_q) : glyph(dec_units);
                    dp_d  = (dp_cnt_d == 8'd0);
                end
                2'd1:    seg_d = (!mode_q && shadow_q >= 4'd10) ? SegOne : SegOff;
                2'd2:    seg_d = SegOff;
                default: seg_d = mode_q ? SegH : SegDec;
            endcase
        end
    end

    always_ff @(posedge ssdd_clk or negedge ssdd_rst) begin
        if (!ssdd_rst) begin
            pre_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 4'd0;
            prev_q   <= 4'd0;
            mode_q   <= 1'b0;
            frame_q  <= 1'b0;
            dp_cnt_q <= 8'd0;
            an_q     <= 4'b1111;
            seg_q    <= SegOff;
            dp_q     <= 1'b1;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            prev_q   <= prev_d;
            mode_q   <= mode_d;
            frame_q  <= frame_d;
            dp_cnt_q <= dp_cnt_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign ssdd_an  = an_q;
    assign ssdd_seg = seg_q;
    assign ssdd_dp  = dp_q;

endmodule

// File: tb/tb_ssdd_scan.sv
// Scoreboard bench for ssdd_scan: stimulus pushes expected digit slots per frame,
// a negedge monitor pops one entry per lit slot and also checks guard and slot lengths.
module tb_ssdd_scan;
    localparam int R = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic       hex;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int          tests;
    int          fails;
    bit          mon_en;
    logic [11:0] exp_q[$];

    ssdd_scan #(
        .REFRESH_DIV(R),
        .DP_FRAMES  (2)
    ) dut (
        .ssdd_clk(clk),
        .ssdd_rst(rst_n),
        .ssdd_d  (d),
        .ssdd_hex(hex),
        .ssdd_an (an),
        .ssdd_seg(seg),
        .ssdd_dp (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s3,
                              input logic dp0);
        exp_q.push_back({4'b1110, s0, dp0});
        exp_q.push_back({4'b1101, s1, 1'b1});
        exp_q.push_back({4'b1011, 7'h7F, 1'b1});
        exp_q.push_back({4'b0111, s3, 1'b1});
    endtask

    // Called one cycle after a frame boundary; returns one cycle after the next boundary,
    // where dv/h are latched. The expected display is for the frame that follows it.
    task automatic run_entry(input logic [3:0] dv, input logic h, input bit tog,
                             input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s3,
                             input logic dp0);
        hex = h;
        d   = tog ? 4'($urandom_range(0, 15)) : dv;
        push_frame(s0, s1, s3, dp0);
        if (tog) begin
            for (int i = 0; i < 15; i++) begin
                @(posedge clk);
                #1;
                d = (i == 14) ? dv : 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            #1;
        end else begin
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        repeat (16) @(posedge clk);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
    endtask

    // Monitor
    logic [11:0] cur_exp;
    bit          lit;
    int          lit_len;
    int          off_len;

    always @(negedge clk) begin
        if (!mon_en) begin
            lit     = 1'b0;
            lit_len = 0;
            off_len = 0;
        end else if (an == 4'b1111) begin
            check("guard_blank", 32'({seg, dp}), 32'({7'h7F, 1'b1}));
            if (lit) begin
                check("slot_len", 32'(lit_len), 32'(R - 1));
                lit     = 1'b0;
                off_len = 0;
            end
            off_len++;
        end else if (!lit) begin
            check("guard_len", 32'(off_len), 32'd1);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL slot_unexpected: got %h, expected none at %0t", {an, seg, dp},
                         $time);
                cur_exp = {an, seg, dp};
            end else begin
                cur_exp = exp_q.pop_front();
                check("slot", 32'({an, seg, dp}), 32'(cur_exp));
            end
            lit     = 1'b1;
            lit_len = 1;
            off_len = 0;
        end else begin
            lit_len++;
            check("slot_hold", 32'({an, seg, dp}), 32'(cur_exp));
        end
    end

    initial begin
        tests  = 0;
        fails  = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        d      = 4'hA;
        hex    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'({an, seg, dp}), 32'({4'b1111, 7'h7F, 1'b1}));

        rst_n  = 1'b1;
        mon_en = 1'b1;
        push_frame(7'h40, 7'h7F, 7'h21, 1'b1);
        //        d      hex   tog   d0     d1     d3     dp
        run_entry(4'd0,  1'b0, 1'b0, 7'h40, 7'h7F, 7'h21, 1'b1);
        run_entry(4'd13, 1'b0, 1'b0, 7'h30, 7'h79, 7'h21, 1'b1);
        run_entry(4'd7,  1'b0, 1'b0, 7'h78, 7'h7F, 7'h21, 1'b0);
        run_entry(4'd14, 1'b1, 1'b0, 7'h06, 7'h7F, 7'h09, 1'b0);
        run_entry(4'd14, 1'b1, 1'b0, 7'h06, 7'h7F, 7'h09, 1'b1);
        run_entry(4'd15, 1'b1, 1'b0, 7'h0E, 7'h7F, 7'h09, 1'b1);
        run_entry(4'd0,  1'b1, 1'b0, 7'h40, 7'h7F, 7'h09, 1'b0);
        run_entry(4'd0,  1'b1, 1'b0, 7'h40, 7'h7F, 7'h09, 1'b0);
        run_entry(4'd0,  1'b1, 1'b0, 7'h40, 7'h7F, 7'h09, 1'b1);
        run_entry(4'd15, 1'b0, 1'b0, 7'h12, 7'h79, 7'h21, 1'b1);
        run_entry(4'd3,  1'b0, 1'b0, 7'h30, 7'h7F, 7'h21, 1'b0);
        run_entry(4'd9,  1'b0, 1'b0, 7'h10, 7'h7F, 7'h21, 1'b0);
        run_entry(4'd2,  1'b0, 1'b0, 7'h24, 7'h7F, 7'h21, 1'b0);
        run_entry(4'd2,  1'b0, 1'b0, 7'h24, 7'h7F, 7'h21, 1'b0);
        run_entry(4'd2,  1'b0, 1'b0, 7'h24, 7'h7F, 7'h21, 1'b1);
        run_entry(4'd10, 1'b0, 1'b0, 7'h40, 7'h79, 7'h21, 1'b1);
        run_entry(4'd11, 1'b1, 1'b0, 7'h03, 7'h7F, 7'h09, 1'b1);
        run_entry(4'd12, 1'b0, 1'b1, 7'h24, 7'h79, 7'h21, 1'b1);
        run_entry(4'd5,  1'b0, 1'b1, 7'h12, 7'h7F, 7'h21, 1'b0);
        drain();
        check("queue_empty_1", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a lit digit-0 slot, with the dp counter loaded.
        @(posedge clk);
        @(posedge clk);
        #3;
        check("pre_reset_lit", 32'(an), 32'(4'b1110));
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'({an, seg, dp}), 32'({4'b1111, 7'h7F, 1'b1}));
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        push_frame(7'h40, 7'h7F, 7'h21, 1'b1);
        run_entry(4'd0, 1'b0, 1'b0, 7'h40, 7'h7F, 7'h21, 1'b1);
        drain();
        check("queue_empty_2", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
